// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Elastic inter-stage pipeline register carrying a control vector, a
// destination register index and NDATA data words from stage D to stage E.
// A two-entry store (OUT drives the E ports, SKD absorbs one extra bundle)
// lets the upstream side keep a registered ReadyD with no combinational path
// from ReadyE, while still sustaining one bundle per cycle.
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset_n    in   asynchronous active-low reset, clears all storage
//   ValidD     in   upstream presents a valid bundle
//   ReadyD     out  a bundle can be accepted this cycle (registered state only)
//   CtrlD      in   [CTRL_W-1:0]        upstream control vector
//   WriteRegD  in   [REG_W-1:0]         upstream destination register
//   DataD      in   [NDATA*DATA_W-1:0]  upstream data words, word k at k*DATA_W
//   Flush      in   synchronous squash of held and incoming bundles
//   ValidE     out  output bundle valid
//   ReadyE     in   downstream accepts the output bundle this cycle
//   CtrlE      out  [CTRL_W-1:0]        output control vector
//   WriteRegE  out  [REG_W-1:0]         output destination register
//   DataE      out  [NDATA*DATA_W-1:0]  output data words
//   Occupancy  out  [1:0]               bundles held: 0, 1 or 2
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned CTRL_W      = 9,
    parameter int unsigned REG_W       = 5,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NDATA       = 3,
    parameter bit          ZERO_BUBBLE = 1'b1
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    ValidD,
    output logic                    ReadyD,
    input  logic [CTRL_W-1:0]       CtrlD,
    input  logic [REG_W-1:0]        WriteRegD,
    input  logic [NDATA*DATA_W-1:0] DataD,
    input  logic                    Flush,
    output logic                    ValidE,
    input  logic                    ReadyE,
    output logic [CTRL_W-1:0]       CtrlE,
    output logic [REG_W-1:0]        WriteRegE,
    output logic [NDATA*DATA_W-1:0] DataE,
    output logic [1:0]              Occupancy
);

    localparam int unsigned BUS_W = NDATA * DATA_W;

    // Encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q, state_d;

    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic [REG_W-1:0]  out_wreg_q, out_wreg_d;
    logic [BUS_W-1:0]  out_data_q, out_data_d;

    logic [CTRL_W-1:0] skd_ctrl_q, skd_ctrl_d;
    logic [REG_W-1:0]  skd_wreg_q, skd_wreg_d;
    logic [BUS_W-1:0]  skd_data_q, skd_data_d;

    logic              acc;
    logic              xfer;

    // ReadyD and ValidE come straight from the state register.
    assign ReadyD    = (state_q != ST_FULL);
    assign ValidE    = (state_q != ST_EMPTY);
    assign Occupancy = state_q;

    assign acc  = ValidD & ReadyD;
    assign xfer = ValidE & ReadyE;

    always_comb begin
        state_d    = state_q;
        out_ctrl_d = out_ctrl_q;
        out_wreg_d = out_wreg_q;
        out_data_d = out_data_q;
        skd_ctrl_d = skd_ctrl_q;
        skd_wreg_d = skd_wreg_q;
        skd_data_d = skd_data_q;

        if (Flush) begin
            // Held bundles and any same-cycle acceptance are dropped; the
            // data registers keep stale contents, which ValidE=0 hides.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        out_ctrl_d = CtrlD;
                        out_wreg_d = WriteRegD;
                        out_data_d = DataD;
                        state_d    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && xfer) begin
                        out_ctrl_d = CtrlD;
                        out_wreg_d = WriteRegD;
                        out_data_d = DataD;
                    end else if (acc) begin
                        skd_ctrl_d = CtrlD;
                        skd_wreg_d = WriteRegD;
                        skd_data_d = DataD;
                        state_d    = ST_FULL;
                    end else if (xfer) begin
                        state_d    = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // acc cannot be set here since ReadyD is low.
                    if (xfer) begin
                        out_ctrl_d = skd_ctrl_q;
                        out_wreg_d = skd_wreg_q;
                        out_data_d = skd_data_q;
                        state_d    = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_EMPTY;
            out_ctrl_q <= '0;
            out_wreg_q <= '0;
            out_data_q <= '0;
            skd_ctrl_q <= '0;
            skd_wreg_q <= '0;
            skd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            out_ctrl_q <= out_ctrl_d;
            out_wreg_q <= out_wreg_d;
            out_data_q <= out_data_d;
            skd_ctrl_q <= skd_ctrl_d;
            skd_wreg_q <= skd_wreg_d;
            skd_data_q <= skd_data_d;
        end
    end

    // A bubble must never reach the register file or memory, so its control
    // and destination fields are masked; data words are left raw.
    assign CtrlE     = (ZERO_BUBBLE && !ValidE) ? '0 : out_ctrl_q;
    assign WriteRegE = (ZERO_BUBBLE && !ValidE) ? '0 : out_wreg_q;
    assign DataE     = out_data_q;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic inter-stage pipeline register for the five-stage datapath: the general successor of the fixed ID/EX latch. It carries a control vector, a destination register index and NDATA data words from stage D to stage E. It adds a valid/ready handshake, a two-entry skid buffer for stall absorption and a synchronous flush for branch/hazard squashing. Every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) is built from one instance.

## Interface
Parameters:
- CTRL_W, 9, control-vector width (ID/EX: MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, ALUOp[3:0])
- REG_W, 5, destination register index width
- DATA_W, 32, width of one data word
- NDATA, 3, number of data words (ID/EX: ImmExt, ReadData1, ReadData2)
- ZERO_BUBBLE, 1, when 1, CtrlE and WriteRegE read 0 while ValidE=0

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- ValidD  in  1  upstream presents a valid bundle
- ReadyD  out  1  this block can accept a bundle this cycle
- CtrlD  in  CTRL_W  upstream control vector
- WriteRegD  in  REG_W  upstream destination register
- DataD  in  NDATA*DATA_W  upstream data words; word k is bits [k*DATA_W +: DATA_W]
- Flush  in  1  synchronous squash of all held and incoming bundles
- ValidE  out  1  output bundle valid
- ReadyE  in  1  downstream accepts the output bundle this cycle
- CtrlE  out  CTRL_W  output control vector
- WriteRegE  out  REG_W  output destination register
- DataE  out  NDATA*DATA_W  output data words
- Occupancy  out  2  bundles held: 0, 1 or 2

## Operation
- Storage:
  - Output entry (OUT) drives the E ports.
  - Skid entry (SKD) holds a second bundle.
- States:
  - EMPTY: OUT and SKD invalid.
  - ONE: OUT valid, SKD invalid.
  - FULL: both valid.
- Handshake:
  - Input transfer (acc) = ValidD & ReadyD.
  - Output transfer (out) = ValidE & ReadyE.
  - ReadyD = (state != FULL). It is a pure function of registered state, with no combinational path from ReadyE.
- Transitions (Flush=0):
  - EMPTY: acc -> OUT<=D, go to ONE. Otherwise stay.
  - ONE, acc & out: OUT<=D, stay in ONE.
  - ONE, acc & !out: SKD<=D, go to FULL.
  - ONE, !acc & out: go to EMPTY.
  - ONE, otherwise: hold.
  - FULL, out: OUT<=SKD, go to ONE. No input is accepted because ReadyD=0.
  - FULL, otherwise: hold.
- Flush=1 overrides every transition:
  - Next state is EMPTY.
  - An incoming acc in the same cycle is dropped.
  - Data registers need not be cleared.
- Order is preserved: bundles leave in acceptance order. None is duplicated or lost except on Flush.
- ValidE = (state != EMPTY).
- Occupancy: 0, 1 or 2 for EMPTY, ONE, FULL respectively.
- ZERO_BUBBLE=1: CtrlE and WriteRegE are forced to 0 while ValidE=0, so a bubble never writes the register file or memory. DataE is unmasked.
- ZERO_BUBBLE=0: the E ports show the raw OUT register.
- Data words are passed bit-exact; no arithmetic is performed.

## Timing
- Reset (Reset_n=0, asynchronous):
  - State goes to EMPTY.
  - ValidE=0, ReadyD=1, Occupancy=0.
  - CtrlE, WriteRegE and DataE are 0, with all storage registers cleared.
- Release of reset is taken synchronously. The first acceptance can occur on the first rising edge with Reset_n=1.
- Latency: a bundle accepted at edge N appears with ValidE=1 after edge N; it is usable in cycle N+1.
- Throughput: 1 bundle per cycle while ReadyE=1.
- Stall capacity: two bundles. ReadyD falls in the cycle after the second bundle is taken under backpressure.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Flush and ReadyE=1 in the same cycle: the current OUT bundle counts as transferred downstream. It is the consumer's job to gate with Flush if required.

## Test plan
- Reset: drive ValidD=1 and CtrlD=9'h1FF during Reset_n=0 -> ValidE=0, CtrlE=0, ReadyD=1, Occupancy=0 throughout, with no edge dependence.
- Streaming: ReadyE=1, send bundles with DataD words {k, k+1, k+2} for k=1..8 on consecutive cycles -> identical bundles on E, one cycle later each, with no gaps and Occupancy=1.
- Backpressure: ReadyE=0, send bundles A and B -> Occupancy=2 and ReadyD=0 after the second edge; a held third bundle C is not taken. Raise ReadyE -> A, B and C emerge in order with no loss.
- Flush in FULL: hold A and B (Occupancy=2), assert Flush with ValidD=1 carrying C -> next cycle ValidE=0, Occupancy=0, ReadyD=1, CtrlE=0. C never appears.
- Bubble masking (ZERO_BUBBLE=1): state EMPTY after A was consumed with CtrlD=9'h1FF and WriteRegD=5'd17 -> CtrlE=0, WriteRegE=0. Repeat with ZERO_BUBBLE=0 -> CtrlE=9'h1FF, WriteRegE=17.
- Random: 10k cycles of random ValidD, ReadyE and Flush (5%), checked against a 2-deep queue model -> order, no duplication, ReadyD never depends combinationally on ReadyE.
